hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the performance counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports RA1D and RA2D, input, 4 each, the decode-stage register source addresses.
REQ-005 SHALL have ports RA1E, RA2E and WA3E, input, 4 each, the execute-stage source and destination addresses.
REQ-006 SHALL have ports WA3M and WA3W, input, 4 each, the memory- and writeback-stage destination addresses.
REQ-007 SHALL have ports RegWriteE, RegWriteM and RegWriteW, input, 1 each, the per-stage write enables.
REQ-008 SHALL have port MemtoRegE, input, 1, indicating a load in execute.
REQ-009 SHALL have port PCSrcD, input, 1, indicating the decode instruction writes the PC.
REQ-010 SHALL have port BranchTakenE, input, 1, indicating a taken branch resolved in execute.
REQ-011 SHALL have port clr_cnt, input, 1, a synchronous clear of the performance counters.
REQ-012 SHALL have ports ForwardAE and ForwardBE, output, 2 each, the SrcAE and SrcBE forward selects.
REQ-013 SHALL have ports Match_1E_M, Match_1E_W, Match_2E_M and Match_2E_W, output, 1 each, the raw address-match flags.
REQ-014 SHALL have ports StallF, StallD, FlushD and FlushE, output, 1 each, the pipeline register controls.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, the saturating event counters.

Function
REQ-016 SHALL compute Match_1E_M as (RA1E==WA3M), Match_1E_W as (RA1E==WA3W), Match_2E_M as (RA2E==WA3M) and Match_2E_W as (RA2E==WA3W), all combinational.
REQ-017 SHALL set ForwardAE to FWD_M (10) if Match_1E_M&RegWriteM, else to FWD_W (01) if Match_1E_W&RegWriteW, else to FWD_RF (00); the memory stage has priority over writeback; ForwardBE is computed the same way from the Match_2E flags.
REQ-018 SHALL force FWD_RF when the matched address is 4'hF; R15 is never forwarded.
REQ-019 SHALL compute ldr_stall as MemtoRegE & RegWriteE & ((RA1D==WA3E)|(RA2D==WA3E)), combinational.
REQ-020 SHALL implement an FSM with states RUN and PCWAIT plus a 2-bit down-counter pc_cnt.
REQ-021 SHALL move the FSM from RUN to PCWAIT with pc_cnt=2 when PCSrcD & ~ldr_stall & ~BranchTakenE; otherwise it stays in RUN.
REQ-022 SHALL decrement pc_cnt each cycle in PCWAIT, return to RUN on the cycle pc_cnt==0, and ignore PCSrcD while in PCWAIT.
REQ-023 SHALL define pcw_pend as (RUN & PCSrcD & ~ldr_stall) | (PCWAIT & pc_cnt!=0).
REQ-024 SHALL drive StallF = ldr_stall | pcw_pend and StallD = ldr_stall.
REQ-025 SHALL drive FlushD = pcw_pend | PCWAIT | BranchTakenE and FlushE = ldr_stall | BranchTakenE.
REQ-026 SHALL give BranchTakenE priority over a simultaneous PCSrcD: the FSM stays in RUN because the decode instruction is flushed.
REQ-027 SHALL increment stall_cnt in each cycle StallD=1 and flush_cnt in each cycle FlushE=1; both saturate at all-ones with no wrap.
REQ-028 SHALL zero both counters on clr_cnt, which takes priority over an increment in the same cycle.
REQ-029 SHALL make all stall, flush and forward outputs combinational from the inputs and FSM state, with zero latency.

Reset
REQ-030 SHALL on reset set state=RUN, pc_cnt=0, stall_cnt=0 and flush_cnt=0, including when reset arrives mid-PCWAIT.
REQ-031 SHALL, during and after reset with all-zero inputs, present StallF=StallD=FlushD=FlushE=0 and ForwardAE=ForwardBE=00.

Structure
REQ-032 SHALL take the FWD_RF/FWD_W/FWD_M encodings, the RUN/PCWAIT state encodings and the R15 constant from a shared package, hazard_defs.
REQ-033 SHALL instantiate the two counters from one sub-module, sat_counter (parameter width; ports clk, reset, clr, inc, q).

Verification
REQ-034 SHALL cover: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10 and Match_1E_M=Match_1E_W=1.
REQ-035 SHALL cover: RA2E=15, WA3M=15, RegWriteM=1 -> ForwardBE=00.
REQ-036 SHALL cover: MemtoRegE=1, RegWriteE=1, WA3E=4, RA2D=4 for 1 cycle -> StallF=StallD=FlushE=1 that cycle, and stall_cnt goes 0->1.
REQ-037 SHALL cover: PCSrcD pulse at cycle t -> StallF=1 at t..t+2 and 0 at t+3; FlushD=1 at t..t+3; state is RUN at t+4.
REQ-038 SHALL cover: PCSrcD=1 and BranchTakenE=1 together -> FlushD=FlushE=1, and the FSM stays RUN next cycle.
REQ-039 SHALL cover: with CNT_W=4, hold ldr_stall for 20 cycles -> stall_cnt=15; then clr_cnt=1 together with a stall -> stall_cnt=0; then assert reset in PCWAIT -> state=RUN next cycle.

Source files
------------

// File: rtl/hazard_defs.sv
// rtl/hazard_defs.sv - shared encodings and forward-select helper for the hazard unit
package hazard_defs;

    // Forward-select encodings for the execute-stage source muxes
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // R15 is the PC; its value is never taken from a later stage
    localparam logic [3:0] R15 = 4'hF;

    // Number of extra PC-write wait cycles loaded into the down-counter
    localparam logic [1:0] PC_WAIT_CYC = 2'd2;

    typedef enum logic {
        RUN    = 1'b0,
        PCWAIT = 1'b1
    } pc_state_e;

    // Memory stage wins over writeback; R15 always reads the register file
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       hit_m,
        input logic       hit_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != R15) begin
            if (hit_m) begin
                sel = FWD_M;
            end else if (hit_w) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] q
);

    localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] q_q;
    logic [width-1:0] q_d;

    // Clear beats increment; increment stops at all-ones
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {width{1'b1}})) begin
            q_d = q_q + ONE;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall and PC-write flush control
module hazard_ctrl
    import hazard_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    input  logic             clr_cnt,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             Match_1E_M,
    output logic             Match_1E_W,
    output logic             Match_2E_M,
    output logic             Match_2E_W,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pc_state_e  state_q;
    pc_state_e  state_d;
    logic [1:0] pc_cnt_q;
    logic [1:0] pc_cnt_d;
    logic       ldr_stall;
    logic       pcw_pend;

    assign Match_1E_M = (RA1E == WA3M);
    assign Match_1E_W = (RA1E == WA3W);
    assign Match_2E_M = (RA2E == WA3M);
    assign Match_2E_W = (RA2E == WA3W);

    // Forward selects from the raw matches gated by the stage write enables
    always_comb begin
        ForwardAE = fwd_sel(RA1E, Match_1E_M & RegWriteM, Match_1E_W & RegWriteW);
        ForwardBE = fwd_sel(RA2E, Match_2E_M & RegWriteM, Match_2E_W & RegWriteW);
    end

    // A load in execute feeding either decode source must hold decode one cycle
    assign ldr_stall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));

    // PC-write FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_cnt_q <= pc_cnt_d;
        end
    end

    // Next state: a taken branch flushes the PC writer, so it cannot start a wait
    always_comb begin
        state_d  = state_q;
        pc_cnt_d = pc_cnt_q;
        case (state_q)
            RUN: begin
                if (PCSrcD && !ldr_stall && !BranchTakenE) begin
                    state_d  = PCWAIT;
                    pc_cnt_d = PC_WAIT_CYC;
                end
            end
            PCWAIT: begin
                if (pc_cnt_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    pc_cnt_d = pc_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d  = RUN;
                pc_cnt_d = 2'd0;
            end
        endcase
    end

    // Stall and flush outputs, combinational from inputs and FSM state
    always_comb begin
        pcw_pend = 1'b0;
        if (state_q == RUN) begin
            pcw_pend = PCSrcD & ~ldr_stall;
        end else begin
            pcw_pend = (pc_cnt_q != 2'd0);
        end
        StallF = ldr_stall | pcw_pend;
        StallD = ldr_stall;
        FlushD = pcw_pend | (state_q == PCWAIT) | BranchTakenE;
        FlushE = ldr_stall | BranchTakenE;
    end

    sat_counter #(
        .width (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (StallD),
        .q     (stall_cnt)
    );

    sat_counter #(
        .width (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (FlushE),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcD, BranchTakenE, clr_cnt;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W;
    logic          StallF, StallD, FlushD, FlushE;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // model state: cycle number, cycle a PC write was accepted, counter values
    bit m_ok = 1'b0;
    int m_cyc, m_acc, m_sc, m_fc;
    int m_d;
    bit m_inwait, m_ldr, m_pend, m_fe;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
        .clr_cnt(clr_cnt),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcD = 0; BranchTakenE = 0; clr_cnt = 0;
    endtask

    function automatic int exp_fwd(input logic [3:0] src, input logic [3:0] m, input logic [3:0] w,
                                   input logic wm, input logic ww);
        if (src == 4'd15) return 0;
        if (src == m && wm) return 2;
        if (src == w && ww) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] rnd_addr();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    // reference model: compare every cycle, then advance model by one cycle
    always @(negedge clk) begin
        if (!m_ok) begin
            if (reset === 1'b1) begin
                m_ok = 1'b1; m_cyc = 0; m_acc = -100; m_sc = 0; m_fc = 0;
            end
        end else begin
            m_ldr    = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
            m_d      = m_cyc - m_acc;
            m_inwait = (m_d >= 1) && (m_d <= 3);
            m_pend   = m_inwait ? (m_d <= 2) : (PCSrcD && !m_ldr);
            m_fe     = m_ldr || BranchTakenE;
            chk("m_StallF", 32'(StallF), 32'(m_ldr || m_pend));
            chk("m_StallD", 32'(StallD), 32'(m_ldr));
            chk("m_FlushD", 32'(FlushD), 32'(m_pend || m_inwait || BranchTakenE));
            chk("m_FlushE", 32'(FlushE), 32'(m_fe));
            chk("m_FwdA", 32'(ForwardAE), exp_fwd(RA1E, WA3M, WA3W, RegWriteM, RegWriteW));
            chk("m_FwdB", 32'(ForwardBE), exp_fwd(RA2E, WA3M, WA3W, RegWriteM, RegWriteW));
            chk("m_M1M", 32'(Match_1E_M), 32'(RA1E == WA3M));
            chk("m_M1W", 32'(Match_1E_W), 32'(RA1E == WA3W));
            chk("m_M2M", 32'(Match_2E_M), 32'(RA2E == WA3M));
            chk("m_M2W", 32'(Match_2E_W), 32'(RA2E == WA3W));
            chk("m_stall_cnt", 32'(stall_cnt), m_sc);
            chk("m_flush_cnt", 32'(flush_cnt), m_fc);
            if (reset) begin
                m_acc = -100; m_sc = 0; m_fc = 0;
            end else begin
                if (!m_inwait && PCSrcD && !m_ldr && !BranchTakenE) m_acc = m_cyc;
                if (clr_cnt) begin
                    m_sc = 0; m_fc = 0;
                end else begin
                    if (m_ldr) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
                    if (m_fe)  m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
                end
            end
            m_cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sf_exp [5];
        bit fd_exp [5];
        bit pc_drv [5];
        sf_exp = '{1, 1, 1, 0, 0};
        fd_exp = '{1, 1, 1, 1, 0};
        pc_drv = '{1, 1, 1, 0, 0};

        idle();
        reset = 1;
        step();
        @(negedge clk);
        chk("rst_StallF", 32'(StallF), 0);
        chk("rst_StallD", 32'(StallD), 0);
        chk("rst_FlushD", 32'(FlushD), 0);
        chk("rst_FlushE", 32'(FlushE), 0);
        chk("rst_FwdA", 32'(ForwardAE), 0);
        chk("rst_FwdB", 32'(ForwardBE), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        step();
        reset = 0;

        // memory stage beats writeback
        step();
        RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
        @(negedge clk);
        chk("fwdA_mem", 32'(ForwardAE), 2);
        chk("m1m", 32'(Match_1E_M), 1);
        chk("m1w", 32'(Match_1E_W), 1);

        // R15 never forwarded
        step(); idle();
        RA2E = 15; WA3M = 15; RegWriteM = 1;
        @(negedge clk);
        chk("fwdB_r15", 32'(ForwardBE), 0);
        chk("m2m_r15", 32'(Match_2E_M), 1);

        // writeback when memory stage does not match
        step(); idle();
        RA2E = 5; WA3M = 6; RegWriteM = 1; WA3W = 5; RegWriteW = 1;
        @(negedge clk);
        chk("fwdB_wb", 32'(ForwardBE), 1);

        // load-use stall for one cycle
        step(); idle();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 4; RA2D = 4;
        @(negedge clk);
        chk("ld_StallF", 32'(StallF), 1);
        chk("ld_StallD", 32'(StallD), 1);
        chk("ld_FlushE", 32'(FlushE), 1);
        chk("ld_cnt_before", 32'(stall_cnt), 0);
        step(); idle();
        @(negedge clk);
        chk("ld_cnt_after", 32'(stall_cnt), 1);
        chk("ld_StallD_off", 32'(StallD), 0);

        // PC write sequence; PCSrcD held during the wait is ignored
        for (int i = 0; i < 5; i++) begin
            step();
            PCSrcD = pc_drv[i];
            @(negedge clk);
            chk($sformatf("pc_StallF_t%0d", i), 32'(StallF), 32'(sf_exp[i]));
            chk($sformatf("pc_FlushD_t%0d", i), 32'(FlushD), 32'(fd_exp[i]));
        end

        // branch beats PC write
        step(); idle();
        PCSrcD = 1; BranchTakenE = 1;
        @(negedge clk);
        chk("br_FlushD", 32'(FlushD), 1);
        chk("br_FlushE", 32'(FlushE), 1);
        step(); idle();
        @(negedge clk);
        chk("br_run_FlushD", 32'(FlushD), 0);
        chk("br_run_StallF", 32'(StallF), 0);

        // saturation, clear priority, reset mid-wait
        for (int i = 0; i < 20; i++) begin
            step(); idle();
            MemtoRegE = 1; RegWriteE = 1; WA3E = 7; RA1D = 7;
        end
        step(); idle();
        @(negedge clk);
        chk("sat_stall_cnt", 32'(stall_cnt), 15);
        chk("sat_flush_cnt", 32'(flush_cnt), 15);
        step(); idle();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 7; RA1D = 7; clr_cnt = 1;
        step(); idle();
        @(negedge clk);
        chk("clr_stall_cnt", 32'(stall_cnt), 0);
        chk("clr_flush_cnt", 32'(flush_cnt), 0);
        PCSrcD = 1;
        step(); idle();
        reset = 1;
        @(negedge clk);
        chk("rw_FlushD_wait", 32'(FlushD), 1);
        step(); reset = 0;
        @(negedge clk);
        chk("rw_FlushD_run", 32'(FlushD), 0);
        chk("rw_StallF_run", 32'(StallF), 0);

        // randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            step();
            RA1D = rnd_addr(); RA2D = rnd_addr(); RA1E = rnd_addr(); RA2E = rnd_addr();
            WA3E = rnd_addr(); WA3M = rnd_addr(); WA3W = rnd_addr();
            RegWriteE    = ($urandom_range(0, 1) == 1);
            RegWriteM    = ($urandom_range(0, 1) == 1);
            RegWriteW    = ($urandom_range(0, 1) == 1);
            MemtoRegE    = ($urandom_range(0, 2) == 0);
            PCSrcD       = ($urandom_range(0, 5) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            clr_cnt      = ($urandom_range(0, 39) == 0);
            reset        = ($urandom_range(0, 99) == 0);
        end
        step(); idle(); reset = 0;
        step();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
